// File: rtl/gate_sweep_unit.sv
// Self-sequencing truth-table sweeper: steps an N-bit vector through every combination,
// evaluates a selectable reduction gate plus bitwise NOT, and counts the vectors that drive the gate high.
module gate_sweep_unit #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   mode,
    output logic [N-1:0] vec,
    output logic [N-1:0] out_not,
    output logic         out_gate,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_cnt
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST    = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [N-1:0]  VEC_ONE = N'(1);
    localparam logic [N:0]    CNT1_W  = (N + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      mode_q, mode_n;
    logic [N-1:0]    vec_n;
    logic            busy_n, done_n;
    logic [N:0]      ones_n;

    // Gate is purely combinational on registered vec, so it lines up with vec in the same cycle.
    always_comb begin
        case (mode_q)
            3'd1:    out_gate = |vec;
            3'd2:    out_gate = ^vec;
            3'd3:    out_gate = ~&vec;
            3'd4:    out_gate = ~|vec;
            3'd5:    out_gate = ~^vec;
            default: out_gate = &vec;
        endcase
    end

    assign out_not = ~vec;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_q;
        vec_n   = vec;
        busy_n  = busy;
        done_n  = 1'b0;
        ones_n  = ones_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    mode_n  = mode;
                    vec_n   = '0;
                    cnt_n   = '0;
                    ones_n  = '0;
                    busy_n  = 1'b1;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    if (out_gate) begin
                        ones_n = ones_cnt + CNT1_W;
                    end
                    cnt_n = '0;
                    if (vec != '1) begin
                        vec_n = vec + VEC_ONE;
                    end else begin
                        // Last vector finished: vec returns to 0 while done pulses.
                        state_n = DONE;
                        vec_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mode_q   <= '0;
            vec      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ones_cnt <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            mode_q   <= mode_n;
            vec      <= vec_n;
            busy     <= busy_n;
            done     <= done_n;
            ones_cnt <= ones_n;
        end
    end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Scoreboard bench for gate_sweep_unit: three instances (N=3/DWELL=4, N=1/DWELL=1, N=4/DWELL=2).
module tb_gate_sweep_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, start0 = 1'b0;
    logic [2:0] mode0 = 3'd0;
    logic [2:0] vec0, not0;
    logic       gate0, busy0, done0;
    logic [3:0] ones0;

    logic       rst1 = 1'b1, start1 = 1'b0;
    logic [2:0] mode1 = 3'd0;
    logic [0:0] vec1, not1;
    logic       gate1, busy1, done1;
    logic [1:0] ones1;

    logic       rst4 = 1'b1, start4 = 1'b0;
    logic [2:0] mode4 = 3'd0;
    logic [3:0] vec4, not4;
    logic       gate4, busy4, done4;
    logic [4:0] ones4;

    gate_sweep_unit #(.N(3), .DWELL(4)) u_dut0 (
        .clk(clk), .rst(rst0), .start(start0), .mode(mode0), .vec(vec0), .out_not(not0),
        .out_gate(gate0), .busy(busy0), .done(done0), .ones_cnt(ones0));

    gate_sweep_unit #(.N(1), .DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .mode(mode1), .vec(vec1), .out_not(not1),
        .out_gate(gate1), .busy(busy1), .done(done1), .ones_cnt(ones1));

    gate_sweep_unit #(.N(4), .DWELL(2)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start4), .mode(mode4), .vec(vec4), .out_not(not4),
        .out_gate(gate4), .busy(busy4), .done(done4), .ones_cnt(ones4));

    int tests_run = 0;
    int tests_failed = 0;
    int sb[$];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int gateModel(input int m, input int v, input int n);
        int a, o, x, b;
        a = 1; o = 0; x = 0;
        for (int i = 0; i < n; i++) begin
            b = (v >> i) & 1;
            a = a & b;
            o = o | b;
            x = x ^ b;
        end
        case (m)
            1:       return o;
            2:       return x;
            3:       return 1 - a;
            4:       return 1 - o;
            5:       return 1 - x;
            default: return a;
        endcase
    endfunction

    task automatic sample(input int which, output int v, output int nv, output int g,
                          output int b, output int d, output int o);
        case (which)
            0: begin v = int'(vec0); nv = int'(not0); g = int'(gate0); b = int'(busy0); d = int'(done0); o = int'(ones0); end
            1: begin v = int'(vec1); nv = int'(not1); g = int'(gate1); b = int'(busy1); d = int'(done1); o = int'(ones1); end
            default: begin v = int'(vec4); nv = int'(not4); g = int'(gate4); b = int'(busy4); d = int'(done4); o = int'(ones4); end
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after start is sampled.
    task automatic applyStimulus(input int which, input int m, input int exp_ones, input bit push);
        case (which)
            0: begin start0 = 1'b1; mode0 = 3'(m); end
            1: begin start1 = 1'b1; mode1 = 3'(m); end
            default: begin start4 = 1'b1; mode4 = 3'(m); end
        endcase
        if (push) sb.push_back(exp_ones);
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start4 = 1'b0;
    endtask

    task automatic runSweep(input int which, input int m, input int exp_ones, input bit disturb);
        int n, dw, total, mask, ev, env, expv, v, nv, g, b, d, o;
        bit seen;
        n     = (which == 0) ? 3 : (which == 1) ? 1 : 4;
        dw    = (which == 0) ? 4 : (which == 1) ? 1 : 2;
        total = (1 << n) * dw;
        mask  = (1 << n) - 1;
        expv  = -1;
        seen  = 1'b0;
        applyStimulus(which, m, exp_ones, 1'b1);
        for (int cyc = 1; cyc <= total + 1 && !seen; cyc++) begin
            sample(which, v, nv, g, b, d, o);
            if (disturb && cyc == 6) begin
                start0 = 1'b1; mode0 = 3'd1;
            end else if (disturb && cyc == 7) begin
                start0 = 1'b0;
            end
            if (cyc <= total) begin
                ev  = (cyc - 1) / dw;
                env = (~ev) & mask;
                checkOutput($sformatf("vec_c%0d", cyc), v, ev);
                checkOutput($sformatf("out_not_c%0d", cyc), nv, env);
                checkOutput($sformatf("out_gate_c%0d", cyc), g, gateModel(m, ev, n));
                checkOutput($sformatf("busy_c%0d", cyc), b, 1);
                checkOutput($sformatf("done_early_c%0d", cyc), d, 0);
            end else begin
                seen = 1'b1;
                checkOutput("done_pulse", d, 1);
                checkOutput("busy_at_done", b, 0);
                checkOutput("vec_at_done", v, 0);
                if (sb.size() > 0) expv = sb.pop_front();
                checkOutput($sformatf("ones_cnt_w%0d_m%0d", which, m), o, expv);
            end
            @(negedge clk);
        end
        mode0 = 3'd0;
        sample(which, v, nv, g, b, d, o);
        checkOutput("done_once", d, 0);
        checkOutput("busy_after", b, 0);
        checkOutput("ones_hold", o, expv);
    endtask

    int v, nv, g, b, d, o;
    int sig3[6] = '{1, 7, 4, 7, 1, 4};

    initial begin
        // Reset with start held high: nothing may begin.
        start0 = 1'b1; start1 = 1'b1; start4 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample(0, v, nv, g, b, d, o);
        checkOutput("rst_busy", b, 0);
        checkOutput("rst_done", d, 0);
        checkOutput("rst_vec", v, 0);
        checkOutput("rst_ones", o, 0);
        checkOutput("rst_not", nv, 7);
        checkOutput("rst_gate", g, 0);
        sample(2, v, nv, g, b, d, o);
        checkOutput("rst_busy4", b, 0);
        rst0 = 1'b0; rst1 = 1'b0; rst4 = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample(0, v, nv, g, b, d, o);
            checkOutput("idle_busy", b, 0);
            checkOutput("idle_done", d, 0);
        end

        for (int m = 0; m < 6; m++) runSweep(0, m, sig3[m], 1'b0);

        runSweep(0, 0, 1, 1'b1);

        // Mid-sweep reset when vec reaches 5.
        applyStimulus(0, 0, 0, 1'b0);
        v = 0;
        for (int i = 0; i < 40 && v != 5; i++) begin
            sample(0, v, nv, g, b, d, o);
            if (v != 5) @(negedge clk);
        end
        checkOutput("reach_vec5", v, 5);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        sample(0, v, nv, g, b, d, o);
        checkOutput("midrst_vec", v, 0);
        checkOutput("midrst_busy", b, 0);
        checkOutput("midrst_ones", o, 0);
        checkOutput("midrst_done", d, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sample(0, v, nv, g, b, d, o);
            checkOutput("postrst_done", d, 0);
            checkOutput("postrst_busy", b, 0);
        end
        runSweep(0, 2, 4, 1'b0);

        runSweep(1, 2, 1, 1'b0);
        runSweep(2, 0, 1, 1'b0);
        runSweep(2, 1, 15, 1'b0);
        runSweep(2, 3, 15, 1'b0);

        checkOutput("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
